// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage hazard controller. Drives the decoder bubble and the
// PC / IF-ID write enables, inserting stalls for load-use and JR dependencies
// and squash cycles for jumps and branches.
module hazard_unit #(
  parameter bit JR_STALL_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic [5:0] Opcode,
  input  logic [5:0] FuncCode,
  input  logic [4:0] Rs,
  input  logic [4:0] Rt,
  input  logic       Jump,
  input  logic       Branch,
  input  logic       Jr,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_RegWrite,
  input  logic [4:0] ID_EX_WriteReg,
  input  logic       BranchTaken,
  output logic       Bubble,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic [2:0] HazState
);

  localparam int unsigned StateW = 3;
  localparam int unsigned RegW   = 5;
  localparam int unsigned OpW    = 6;

  localparam logic [OpW-1:0] OpRType = 6'b000000;
  localparam logic [OpW-1:0] OpJ     = 6'b000010;
  localparam logic [OpW-1:0] OpJal   = 6'b000011;
  localparam logic [OpW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpW-1:0] OpLui   = 6'b001111;
  localparam logic [OpW-1:0] OpSw    = 6'b101011;

  localparam logic [OpW-1:0] FnSll   = 6'b000000;
  localparam logic [OpW-1:0] FnSrl   = 6'b000010;
  localparam logic [OpW-1:0] FnSra   = 6'b000011;

  localparam logic [StateW-1:0] NoHazard = 3'd0;
  localparam logic [StateW-1:0] Jump0    = 3'd1;
  localparam logic [StateW-1:0] Branch0  = 3'd2;
  localparam logic [StateW-1:0] Branch1  = 3'd3;

  logic [StateW-1:0] state_q;
  logic [StateW-1:0] state_d;

  logic is_rtype;
  logic is_shift;
  logic uses_rs;
  logic uses_rt;
  logic ex_dst_nz;
  logic load_use;
  logic jr_haz;
  logic stall;

  // Which source fields the ID instruction actually reads
  always_comb begin
    is_rtype = (Opcode == OpRType);
    is_shift = is_rtype &&
               ((FuncCode == FnSll) || (FuncCode == FnSrl) || (FuncCode == FnSra));
    uses_rs  = !((Opcode == OpJ) || (Opcode == OpJal) || (Opcode == OpLui) || is_shift);
    uses_rt  = is_rtype || (Opcode == OpBeq) || (Opcode == OpSw);
  end

  // Dependency checks against the EX-stage destination; $0 never stalls
  always_comb begin
    ex_dst_nz = (ID_EX_WriteReg != RegW'(0));
    load_use  = ID_EX_MemRead && ex_dst_nz &&
                ((uses_rs && (ID_EX_WriteReg == Rs)) ||
                 (uses_rt && (ID_EX_WriteReg == Rt)));
    jr_haz    = JR_STALL_EN && Jr && ID_EX_RegWrite && ex_dst_nz &&
                (ID_EX_WriteReg == Rs);
    stall     = load_use || jr_haz;
  end

  // State register; reset aborts any squash sequence
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= NoHazard;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: stall beats branch, branch beats jump; flags ignored mid-sequence
  always_comb begin
    state_d = NoHazard;
    case (state_q)
      NoHazard: begin
        if (stall) begin
          state_d = NoHazard;
        end else if (Branch) begin
          state_d = Branch0;
        end else if (Jump) begin
          state_d = Jump0;
        end else begin
          state_d = NoHazard;
        end
      end
      Jump0:   state_d = NoHazard;
      Branch0: state_d = Branch1;
      Branch1: state_d = NoHazard;
      default: state_d = NoHazard;
    endcase
  end

  // Outputs from state and inputs; reset forces the stalled pattern at once
  always_comb begin
    Bubble    = 1'b0;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    case (state_q)
      Jump0: begin
        Bubble    = 1'b1;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
      end
      Branch0: begin
        Bubble    = 1'b1;
        PCWrite   = BranchTaken;
        IFIDWrite = 1'b0;
      end
      Branch1: begin
        Bubble    = 1'b1;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
      end
      default: begin
        // NO_HAZARD, and illegal encodings behave like NO_HAZARD
        if (stall) begin
          Bubble    = 1'b1;
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
        end else if (Branch) begin
          Bubble    = 1'b0;
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
        end else if (Jump) begin
          Bubble    = 1'b0;
          PCWrite   = 1'b1;
          IFIDWrite = 1'b0;
        end
      end
    endcase
    if (!Reset_L) begin
      Bubble    = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end
  end

  // Debug view of the current state, zero while in reset
  always_comb begin
    HazState = Reset_L ? state_q : NoHazard;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller that drives the decoder's `bubble` input together with the PC and IF/ID write enables. It sits beside the ID stage. It watches the instruction in IF/ID, the decoded `Jump`/`Branch`/`Jr` flags, the ID/EX stage and the EX-stage branch result. A small state machine inserts stalls and squashes for load-use, jump and branch hazards.

## Interface
- `JR_STALL_EN`, default 1: when 1, JR stalls while the EX-stage instruction writes `Rs`; when 0, that check is disabled (datapath forwards).
- `CLK` input, 1 bit: single clock, all state updates on rising edge.
- `Reset_L` input, 1 bit: reset, asynchronous, active-low.
- `Opcode` input, 6 bits: IF/ID instruction [31:26].
- `FuncCode` input, 6 bits: IF/ID instruction [5:0].
- `Rs` input, 5 bits: IF/ID instruction [25:21].
- `Rt` input, 5 bits: IF/ID instruction [20:16].
- `Jump` input, 1 bit: decoder Jump flag (J, JAL, JR) for the ID instruction.
- `Branch` input, 1 bit: decoder Branch flag (BEQ) for the ID instruction.
- `Jr` input, 1 bit: decoder Jr flag for the ID instruction.
- `ID_EX_MemRead` input, 1 bit: instruction in EX is a load.
- `ID_EX_RegWrite` input, 1 bit: instruction in EX writes the register file.
- `ID_EX_WriteReg` input, 5 bits: destination register of the instruction in EX.
- `BranchTaken` input, 1 bit: EX-stage BEQ result; valid only while the branch is in EX.
- `Bubble` output, 1 bit: to the decoder `bubble` input; 1 zeroes all pipelined control for the ID instruction.
- `PCWrite` output, 1 bit: PC register load enable.
- `IFIDWrite` output, 1 bit: IF/ID register load enable.
- `HazState` output, 3 bits: current state encoding, for debug and bench.

## Operation
- States and encodings:
  - NO_HAZARD = 0
  - JUMP_0 = 1
  - BRANCH_0 = 2
  - BRANCH_1 = 3
  - Encodings 4–7 are illegal and return to NO_HAZARD on the next edge, with NO_HAZARD outputs meanwhile.
- Source-register use by the ID instruction:
  - UsesRs = 0 for J (000010), JAL (000011), LUI (001111), and R-type SLL/SRL/SRA; 1 otherwise.
  - UsesRt = 1 for R-type, BEQ (000100) and SW (101011); 0 otherwise.
- LoadUse = `ID_EX_MemRead` & (`ID_EX_WriteReg` != 0) & ((UsesRs & `ID_EX_WriteReg`==`Rs`) | (UsesRt & `ID_EX_WriteReg`==`Rt`)).
- JrHaz = `JR_STALL_EN` & `Jr` & `ID_EX_RegWrite` & (`ID_EX_WriteReg` != 0) & (`ID_EX_WriteReg`==`Rs`).
- NO_HAZARD, evaluated in priority order:
  1. LoadUse or JrHaz: `Bubble`=1, `PCWrite`=0, `IFIDWrite`=0; stay in NO_HAZARD and re-evaluate next cycle.
  2. Else `Branch`: `Bubble`=0, `PCWrite`=0, `IFIDWrite`=0. Go to BRANCH_0.
  3. Else `Jump`: `Bubble`=0, `PCWrite`=1 (PC loads the jump target), `IFIDWrite`=0. Go to JUMP_0.
  4. Else: `Bubble`=0, `PCWrite`=1, `IFIDWrite`=1.
- JUMP_0: the stale jump copy is still in IF/ID. `Bubble`=1, `PCWrite`=1, `IFIDWrite`=1. Go to NO_HAZARD.
- BRANCH_0: the branch is in EX. `Bubble`=1, `PCWrite`=`BranchTaken` (taken: PC loads the target; not taken: PC holds branch+4), `IFIDWrite`=0. Go to BRANCH_1.
- BRANCH_1: `Bubble`=1, `PCWrite`=1, `IFIDWrite`=1. Go to NO_HAZARD.
- `Jump`, `Branch`, LoadUse and JrHaz are ignored in JUMP_0, BRANCH_0 and BRANCH_1; the stale ID copy still raises its flags and must not retrigger.
- Outputs are combinational from state and inputs; only the state register is clocked.

## Timing
- Reset:
  - While `Reset_L`=0: state = NO_HAZARD, `HazState`=0, `Bubble`=1, `PCWrite`=0, `IFIDWrite`=0, all forced immediately and asynchronously.
  - Reset mid-sequence aborts any JUMP/BRANCH sequence.
  - First rising edge after deassertion evaluates NO_HAZARD normally.
- Penalties:
  - Load-use: 1 bubble cycle per stalled cycle. The hazard clears once the load reaches MEM and ID/EX holds the bubble.
  - Jump: exactly 1 squash cycle.
  - Branch: exactly 2 cycles after the branch enters EX, taken or not.
- Simultaneous events:
  - LoadUse with `Branch` or `Jump`: the stall wins; the branch or jump proceeds on the following cycle.
  - `Branch` and `Jump` both high: `Branch` wins.
- Register 0 never causes a stall.
- `BranchTaken` is sampled only in BRANCH_0.

## Test plan
- Reset: hold `Reset_L`=0 over 3 edges → `Bubble`=1, `PCWrite`=0, `IFIDWrite`=0, `HazState`=0. Release → `Bubble`=0, `PCWrite`=1, `IFIDWrite`=1.
- Load-use: EX = LW to $8, ID = ADD using rs=$8 → 1 cycle with `Bubble`=1, `PCWrite`=0, `IFIDWrite`=0. Then EX = bubble → normal outputs. Same case with `ID_EX_WriteReg`=0 → no stall.
- Jump: J in ID → cycle 0: `PCWrite`=1, `IFIDWrite`=0, `HazState` 0→1. Cycle 1: `Bubble`=1, `PCWrite`=1, `IFIDWrite`=1. Back to state 0.
- Branch, both outcomes:
  - BEQ taken → states 0→2→3→0. `PCWrite` = 0, 1, 1. `Bubble` = 0, 1, 1.
  - BEQ not taken → same state walk, but `PCWrite`=0 in BRANCH_0.
- JR hazard: ADD writing $31 in EX, JR $31 in ID.
  - `JR_STALL_EN`=1 → 1 stall cycle, then the jump sequence.
  - `JR_STALL_EN`=0 → immediate jump sequence.
- Async reset asserted in BRANCH_0 → `HazState`=0 and outputs forced before the next edge. LW hazard coinciding with BEQ in ID → stall first, then branch sequence.
